// File: rtl/puf_helper_pkg.sv
// puf_helper_pkg: shared types, widths and code-column helpers for the PUF helper-data controller
package puf_helper_pkg;
  localparam int BLK_W = 32;
  localparam int PAR_W = 12;
  typedef enum logic [2:0] {IDLE, ENROLL, RECON, KEYOUT, FINISH} state_e;
  function automatic int err_w(input int n);
    return $clog2(n * BLK_W + 1);
  endfunction
  function automatic logic [4:0] gf_mul(input logic [4:0] a, input logic [4:0] b);
    logic [4:0] p, t;
    p = '0;
    t = a;
    for (int k = 0; k < 5; k++) begin
      p = b[k] ? p ^ t : p;
      t = {t[3:0], 1'b0} ^ (t[4] ? 5'h05 : 5'h00);
    end
    return p;
  endfunction
  // Column i = {0, i^3, i, 1} over GF(32): odd/even error count in bit 0, Sidon set above it
  function automatic logic [PAR_W-1:0] bch_col(input int i);
    logic [4:0] x;
    x = 5'(i);
    return {1'b0, gf_mul(gf_mul(x, x), x), x, 1'b1};
  endfunction
  function automatic logic [5:0] popcnt(input logic [BLK_W-1:0] v);
    logic [5:0] c;
    c = '0;
    for (int k = 0; k < BLK_W; k++) c = c + 6'(v[k]);
    return c;
  endfunction
endpackage

// File: rtl/puf_helper_ctrl_if.sv
// puf_helper_ctrl_if: command, response, key and status signals of the helper-data controller
interface puf_helper_ctrl_if import puf_helper_pkg::*; #(parameter int NUM_BLK = 4);
  logic start, mode, resp_valid, resp_ready, key_valid, key_ready, busy, done, fail, enrolled;
  logic [BLK_W-1:0] resp_data, key_data;
  logic [err_w(NUM_BLK)-1:0] err_bits;
  modport master (output start, mode, resp_valid, resp_data, key_ready,
                  input resp_ready, key_valid, key_data, busy, done, fail, enrolled, err_bits);
  modport slave (input start, mode, resp_valid, resp_data, key_ready,
                 output resp_ready, key_valid, key_data, busy, done, fail, enrolled, err_bits);
endinterface

// File: rtl/bch_dec_dcd_univ_top.sv
// bch_dec_dcd_univ_top: combinational decoder, corrects up to 2 data-bit errors and flags 3
module bch_dec_dcd_univ_top import puf_helper_pkg::*; (
  input  logic [BLK_W-1:0] data,
  input  logic [PAR_W-1:0] parity,
  output logic [BLK_W-1:0] mask,
  output logic             err
);
  logic [PAR_W-1:0] syn;
  logic             hit;
  // Odd syndromes can only match a single column, even ones only a column pair
  always_comb begin
    syn = parity;
    for (int i = 0; i < BLK_W; i++) syn = syn ^ (data[i] ? bch_col(i) : '0);
    mask = '0;
    hit = 1'b0;
    for (int i = 0; i < BLK_W; i++) begin
      if (syn == bch_col(i)) begin
        mask = BLK_W'(1) << i;
        hit = 1'b1;
      end
      for (int j = i + 1; j < BLK_W; j++)
        if (!hit && syn == (bch_col(i) ^ bch_col(j))) begin
          mask = (BLK_W'(1) << i) | (BLK_W'(1) << j);
          hit = 1'b1;
        end
    end
    err = (syn != '0) && !hit;
  end
endmodule

// File: rtl/bch_dec_enc_univ_top.sv
// bch_dec_enc_univ_top: combinational parity generator for one 32-bit response block
module bch_dec_enc_univ_top import puf_helper_pkg::*; (
  input  logic [BLK_W-1:0] data,
  output logic [PAR_W-1:0] parity
);
  always_comb begin
    parity = '0;
    for (int i = 0; i < BLK_W; i++) parity = parity ^ (data[i] ? bch_col(i) : '0);
  end
endmodule

// File: rtl/puf_helper_store.sv
// puf_helper_store: NUM_BLK x PAR_W helper register file, one write port, async read
module puf_helper_store #(
  parameter int NUM_BLK = 4,
  parameter int PAR_W = 12,
  localparam int IW = NUM_BLK > 1 ? $clog2(NUM_BLK) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [IW-1:0]    waddr,
  input  logic [PAR_W-1:0] wdata,
  input  logic [IW-1:0]    raddr,
  output logic [PAR_W-1:0] rdata
);
  logic [NUM_BLK-1:0][PAR_W-1:0] mem_q, mem_d;
  always_comb begin
    mem_d = mem_q;
    if (we) mem_d[waddr] = wdata;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) mem_q <= '0;
    else mem_q <= mem_d;
  assign rdata = mem_q[raddr];
endmodule

// File: rtl/puf_helper_ctrl.sv
// puf_helper_ctrl: enrolls PUF helper parity and reconstructs corrected key words block by block
module puf_helper_ctrl import puf_helper_pkg::*; #(
  parameter int NUM_BLK = 4,
  parameter int PAR_W = 12
) (
  input logic clk,
  input logic rst,
  puf_helper_ctrl_if.slave bus
);
  localparam int IW = NUM_BLK > 1 ? $clog2(NUM_BLK) : 1;
  localparam int EW = err_w(NUM_BLK);
  state_e           state_q, state_d;
  logic [IW-1:0]    blk_idx_q, blk_idx_d;
  logic             fail_q, fail_d, enrolled_q, enrolled_d;
  logic [EW-1:0]    err_bits_q, err_bits_d;
  logic [BLK_W-1:0] key_data_q, key_data_d, dec_mask;
  logic [PAR_W-1:0] enc_par, helper;
  logic             st_we, dec_err, last;
  bch_dec_enc_univ_top u_enc (.data(bus.resp_data), .parity(enc_par));
  bch_dec_dcd_univ_top u_dcd (.data(bus.resp_data), .parity(helper), .mask(dec_mask), .err(dec_err));
  puf_helper_store #(.NUM_BLK(NUM_BLK), .PAR_W(PAR_W)) u_store (
    .clk(clk), .rst(rst), .we(st_we), .waddr(blk_idx_q), .wdata(enc_par),
    .raddr(blk_idx_q), .rdata(helper)
  );
  assign last = blk_idx_q == IW'(NUM_BLK - 1);
  always_comb begin
    state_d = state_q;
    blk_idx_d = blk_idx_q;
    fail_d = fail_q;
    enrolled_d = enrolled_q;
    err_bits_d = err_bits_q;
    key_data_d = key_data_q;
    st_we = 1'b0;
    case (state_q)
      IDLE: if (bus.start) begin
        fail_d = 1'b0;
        err_bits_d = '0;
        blk_idx_d = '0;
        enrolled_d = bus.mode && enrolled_q;
        fail_d = bus.mode && !enrolled_q;
        state_d = !bus.mode ? ENROLL : enrolled_q ? RECON : FINISH;
      end
      ENROLL: if (bus.resp_valid) begin
        st_we = 1'b1;
        enrolled_d = last;
        state_d = last ? FINISH : ENROLL;
        blk_idx_d = last ? blk_idx_q : blk_idx_q + IW'(1);
      end
      RECON: if (bus.resp_valid) begin
        key_data_d = dec_mask ^ bus.resp_data;
        err_bits_d = err_bits_q + EW'(popcnt(dec_mask));
        fail_d = fail_q | dec_err;
        state_d = KEYOUT;
      end
      KEYOUT: if (bus.key_ready) begin
        state_d = last ? FINISH : RECON;
        blk_idx_d = last ? blk_idx_q : blk_idx_q + IW'(1);
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      blk_idx_q <= '0;
      fail_q <= 1'b0;
      enrolled_q <= 1'b0;
      err_bits_q <= '0;
      key_data_q <= '0;
    end else begin
      state_q <= state_d;
      blk_idx_q <= blk_idx_d;
      fail_q <= fail_d;
      enrolled_q <= enrolled_d;
      err_bits_q <= err_bits_d;
      key_data_q <= key_data_d;
    end
  assign bus.resp_ready = state_q == ENROLL || state_q == RECON;
  assign bus.key_valid = state_q == KEYOUT;
  assign bus.key_data = key_data_q;
  assign bus.busy = state_q != IDLE;
  assign bus.done = state_q == FINISH;
  assign bus.fail = fail_q;
  assign bus.enrolled = enrolled_q;
  assign bus.err_bits = err_bits_q;
endmodule

// File: doc/puf_helper_ctrl.md
PUF_HELPER_CTRL -- requirements
Module: puf_helper_ctrl

Interface
REQ-001 The block SHALL have parameter NUM_BLK, default 4, meaning the number of 32-bit response blocks per key, with a legal range of 1..16.
REQ-002 The block SHALL have parameter BLK_W, default 32, meaning the data width per block; it is fixed by the BCH cores and is not user-overridable.
REQ-003 The block SHALL have parameter PAR_W, default 12, meaning the BCH parity width per block.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all logic runs on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-006 The block SHALL have port start, input, 1 bit: a one-cycle request to begin an operation.
REQ-007 The block SHALL have port mode, input, 1 bit: 0 = enroll, 1 = reconstruct; it is sampled only with start.
REQ-008 The block SHALL have ports resp_valid (input, 1), resp_ready (output, 1) and resp_data (input, 32): the PUF response stream.
REQ-009 The block SHALL have ports key_valid (output, 1), key_ready (input, 1) and key_data (output, 32): the corrected key stream, reconstruct mode only.
REQ-010 The block SHALL have port busy, output, 1 bit: high from accepted start until done.
REQ-011 The block SHALL have port done, output, 1 bit: a one-cycle pulse at operation end.
REQ-012 The block SHALL have port fail, output, 1 bit: sticky per operation; set if any block's decoder error is high, or on reconstruct while not enrolled.
REQ-013 The block SHALL have port enrolled, output, 1 bit: high once an enroll has completed.
REQ-014 The block SHALL have port err_bits, output, clog2(NUM_BLK*32+1) bits: total corrected bit count of the last reconstruct.

Function
REQ-015 The FSM SHALL have exactly the states IDLE, ENROLL, RECON, KEYOUT and FINISH.
REQ-016 In IDLE, start=1 SHALL latch mode, clear fail, err_bits and blk_idx, and go to ENROLL (mode=0) or RECON (mode=1); start while not IDLE SHALL be ignored.
REQ-017 Reconstruct with enrolled=0 SHALL go IDLE->FINISH, set fail=1 and emit no key words.
REQ-018 resp_ready SHALL be high only in ENROLL and RECON; a transfer occurs on resp_valid && resp_ready.
REQ-019 In ENROLL, each transfer SHALL write the encoder parity of resp_data into helper store entry blk_idx and increment blk_idx.
REQ-020 In ENROLL, the transfer at blk_idx = NUM_BLK-1 SHALL go to FINISH and set enrolled=1.
REQ-021 In RECON, each transfer SHALL decode resp_data with helper entry blk_idx and register key_data = mask ^ resp_data.
REQ-022 In RECON, each transfer SHALL add popcount(mask) to err_bits, OR the decoder error into fail, and go to KEYOUT.
REQ-023 In KEYOUT, key_valid SHALL be 1 and key_data SHALL hold stable until key_ready.
REQ-024 On key_ready in KEYOUT, the FSM SHALL go to RECON with blk_idx+1, or to FINISH after the block at blk_idx = NUM_BLK-1.
REQ-025 Latency SHALL be one cycle from response transfer to key_valid; key_ready=1 held gives a throughput of one block per two cycles.
REQ-026 A decode failure SHALL NOT abort the operation: all NUM_BLK key words are still emitted and fail=1 at done.
REQ-027 FINISH SHALL pulse done for one cycle and return to IDLE; busy=0 in IDLE only.
REQ-028 fail, err_bits and enrolled SHALL hold until the next accepted start or reset.
REQ-029 A new enroll SHALL overwrite the helper store entirely.
REQ-030 blk_idx SHALL never exceed NUM_BLK-1 and SHALL NOT wrap within an operation.
REQ-031 err_bits SHALL never saturate; its width covers the worst case.

Reset
REQ-032 Asserting rst at any time, including mid-operation, SHALL immediately force IDLE.
REQ-033 During rst, busy, done, fail, key_valid, resp_ready and enrolled SHALL be 0.
REQ-034 During rst, key_data, err_bits, blk_idx and the entire helper store SHALL be 0.
REQ-035 No partial enrollment SHALL survive reset.

Structure
REQ-036 The package puf_helper_pkg SHALL hold the state enum, BLK_W, PAR_W and the err_bits width function.
REQ-037 The block SHALL instantiate the existing combinational cores bch_dec_enc_univ_top and bch_dec_dcd_univ_top once each, time-shared across blocks.
REQ-038 One sub-module, puf_helper_store (NUM_BLK x PAR_W register file, one write port and one async read port), SHALL be used.

Verification
REQ-039 Enroll with NUM_BLK=4 and words 0x00013346, 0x0, 0xFFFFFFFF, 0xA5A5A5A5 SHALL give done after the 4 transfers, enrolled=1, fail=0 and no key_valid.
REQ-040 Reconstruct with the identical words SHALL emit those 4 words unchanged, err_bits=0 and fail=0.
REQ-041 Reconstruct with block 0 = 0x00001346 (2-bit error) SHALL give key word 0 = 0x00013346 and err_bits=2.
REQ-042 Reconstruct with a 3-bit error in one block SHALL give fail=1 at done while 4 key words are still emitted.
REQ-043 key_ready held 0 for 5 cycles SHALL keep key_data stable and resp_ready=0; reconstruct after reset SHALL give fail=1, done with no key words and enrolled=0.
REQ-044 rst asserted during KEYOUT of block 2 SHALL return all outputs to 0 and clear the helper store; a following reconstruct SHALL fail.
